key_event_queue: RTL and testbench
==================================

KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of 2, 2..64).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer flops per incoming strobe (≥2).
REQ-003 SHALL have port clk, input, 1, meaning system clock; all state on posedge clk.
REQ-004 SHALL have port rst, input, 1, meaning reset; asynchronous, active-low.
REQ-005 SHALL have port frame, input, 11, meaning the receiver's PS/2 frame: [10] start, [9] parity, [8:1] scancode, [0] stop.
REQ-006 SHALL have port frame_latch, input, 1, meaning the receiver's data-byte strobe; asynchronous to clk.
REQ-007 SHALL have port bat_strobe, input, 1, meaning the receiver's 0xAA self-test strobe; asynchronous.
REQ-008 SHALL have port release_strobe, input, 1, meaning the receiver's 0xF0 prefix strobe; asynchronous.
REQ-009 SHALL have port extended_strobe, input, 1, meaning the receiver's 0xE0 prefix strobe; asynchronous.
REQ-010 SHALL have port ev_data, output, 10, meaning head event {extended, released, code[7:0]}.
REQ-011 SHALL have port ev_valid, output, 1, meaning FIFO non-empty.
REQ-012 SHALL have port ev_ready, input, 1, meaning consumer pop request.
REQ-013 SHALL have port overflow, output, 1, meaning sticky; an event was dropped because the FIFO was full.
REQ-014 SHALL have port kbd_reset, output, 1, meaning one-cycle pulse on a self-test strobe.
REQ-015 SHALL have port err_count, output, 8, meaning saturating count of dropped bad frames.

Function
REQ-016 SHALL pass each strobe through SYNC_STAGES flops, then detect its rising edge; a detected edge is "event", one clk cycle long.
REQ-017 SHALL sample frame on the frame_latch event cycle (frame is stable for ≥1 PS/2 bit time).
REQ-018 SHALL define a frame as good iff frame[10]=0, frame[0]=1 and ^frame[9:1]=1 (odd parity).
REQ-019 SHALL hold prefix FSM states IDLE, EXT, REL, EXT_REL.
REQ-020 SHALL transition on an extended event: IDLE->EXT, REL->EXT_REL, and otherwise hold state.
REQ-021 SHALL transition on a release event: IDLE->REL, EXT->EXT_REL, and otherwise hold state.
REQ-022 SHALL, on a good frame event, push {state∈{EXT,EXT_REL}, state∈{REL,EXT_REL}, frame[8:1]} and return to IDLE.
REQ-023 SHALL, on a bad frame event, push nothing, increment err_count (saturate at 255) and return to IDLE.
REQ-024 SHALL, on a bat event, pulse kbd_reset for 1 cycle next clk, flush the FIFO, return to IDLE, and leave overflow/err_count unchanged.
REQ-025 SHALL apply priority bat > frame > extended > release when events coincide; lower-priority events in that cycle are discarded.
REQ-026 SHALL have push latency: ev_valid high on the clk after the frame event when the FIFO was empty.
REQ-027 SHALL pop when ev_valid && ev_ready; ev_ready while empty has no effect.
REQ-028 SHALL drop a push when full and not popping that cycle, and set overflow; a push and a pop in the same full cycle both succeed.
REQ-029 SHALL wrap read/write pointers modulo DEPTH, with occupancy 0..DEPTH tracked exactly.
REQ-030 SHALL hold ev_data stable while ev_valid && !ev_ready.
REQ-031 SHALL clear overflow only by reset.

Reset
REQ-032 SHALL, while rst=0, clear synchronizers, edge detectors, FSM (IDLE), pointers and occupancy.
REQ-033 SHALL, while rst=0, drive ev_valid=0, ev_data=0, overflow=0, kbd_reset=0, err_count=0.
REQ-034 SHALL discard any event in flight when reset is asserted mid-operation; a strobe already high at deassertion SHALL NOT produce an event.

Verification
REQ-035 SHALL cover: extended, release, then frame code 0x75 with good parity -> one entry 0x375 (ext=1, rel=1), ev_valid one clk after frame event.
REQ-036 SHALL cover: frame 0x1C with parity bit flipped -> no push, err_count=1, FSM IDLE; 256 further bad frames -> err_count=255.
REQ-037 SHALL cover: DEPTH+1 good frames with ev_ready=0 -> DEPTH entries, overflow=1, and first-in entry at head; draining returns them in order.
REQ-038 SHALL cover: FIFO full, a push and a pop in the same cycle -> occupancy stays DEPTH, overflow stays 0.
REQ-039 SHALL cover: 3 queued entries then bat_strobe -> kbd_reset 1-cycle pulse, ev_valid=0, err_count unchanged.
REQ-040 SHALL cover: rst asserted between extended event and frame -> after release, frame 0x1C -> entry 0x01C.

Source files
------------

// File: rtl/key_event_queue.sv
// rtl/key_event_queue.sv - PS/2 key event synchronizer, prefix decoder and event FIFO
module key_event_queue #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] frame,
  input  logic        frame_latch,
  input  logic        bat_strobe,
  input  logic        release_strobe,
  input  logic        extended_strobe,
  output logic [9:0]  ev_data,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic        overflow,
  output logic        kbd_reset,
  output logic [7:0]  err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(SYNC_STAGES + 2);
  localparam logic [BW-1:0] BLANK_DONE = BW'(SYNC_STAGES + 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, REL, EXT_REL} state_t;

  // Strobe order inside the packed vectors: [3] bat, [2] frame, [1] extended, [0] release
  logic [3:0]                  w_strobe_in;
  logic [3:0][SYNC_STAGES-1:0] r_sync;
  logic [3:0]                  r_prev;
  logic [3:0]                  w_edge;
  logic [BW-1:0]               r_blank;
  logic                        w_armed;

  logic w_bat_ev, w_frame_ev, w_ext_ev, w_rel_ev;
  logic w_frame_good;

  state_t r_state, w_state_next;
  logic       w_push, w_bad, w_flush;
  logic [9:0] w_push_data;

  logic [9:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic w_empty, w_full, w_pop, w_wr;

  assign w_strobe_in = {bat_strobe, frame_latch, extended_strobe, release_strobe};

  // Synchronizer chains plus the previous-value flop for rising-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_strobe_in[i]};
        r_prev[i] <= r_sync[i][SYNC_STAGES-1];
      end
    end
  end

  // Blank edges until a strobe held high across reset release has reached r_prev
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blank <= '0;
    end else if (r_blank != BLANK_DONE) begin
      r_blank <= r_blank + BW'(1);
    end
  end

  assign w_armed = (r_blank == BLANK_DONE);

  // One-cycle events from the synchronized rising edges
  always_comb begin
    w_edge = '0;
    for (int i = 0; i < 4; i++) begin
      w_edge[i] = w_armed & r_sync[i][SYNC_STAGES-1] & ~r_prev[i];
    end
  end

  assign w_rel_ev     = w_edge[0];
  assign w_ext_ev     = w_edge[1];
  assign w_frame_ev   = w_edge[2];
  assign w_bat_ev     = w_edge[3];
  assign w_frame_good = ~frame[10] & frame[0] & (^frame[9:1]);

  // Prefix FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Prefix FSM next state; bat beats frame beats extended beats release
  always_comb begin
    w_state_next = r_state;
    if (w_bat_ev || w_frame_ev) begin
      w_state_next = IDLE;
    end else if (w_ext_ev) begin
      case (r_state)
        IDLE:    w_state_next = EXT;
        REL:     w_state_next = EXT_REL;
        default: w_state_next = r_state;
      endcase
    end else if (w_rel_ev) begin
      case (r_state)
        IDLE:    w_state_next = REL;
        EXT:     w_state_next = EXT_REL;
        default: w_state_next = r_state;
      endcase
    end
  end

  // Prefix FSM outputs: push request, bad-frame strike, flush
  always_comb begin
    w_flush     = w_bat_ev;
    w_push      = w_frame_ev & ~w_bat_ev & w_frame_good;
    w_bad       = w_frame_ev & ~w_bat_ev & ~w_frame_good;
    w_push_data = {(r_state == EXT) || (r_state == EXT_REL),
                   (r_state == REL) || (r_state == EXT_REL),
                   frame[8:1]};
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_COUNT);
  assign w_pop   = ~w_empty & ev_ready;
  assign w_wr    = w_push & (~w_full | w_pop);

  // FIFO pointers and occupancy; a flush discards everything queued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      if (w_wr && !w_pop) r_count <= r_count + (AW + 1)'(1);
      else if (!w_wr && w_pop) r_count <= r_count - (AW + 1)'(1);
    end
  end

  // FIFO storage; contents are only visible while occupancy is nonzero
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_push_data;
  end

  // Sticky overflow, saturating error count and self-test reset pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      err_count <= '0;
      kbd_reset <= 1'b0;
    end else begin
      kbd_reset <= w_bat_ev;
      if (w_push && w_full && !w_pop) overflow <= 1'b1;
      if (w_bad && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  assign ev_valid = ~w_empty;
  assign ev_data  = w_empty ? 10'd0 : r_mem[r_rptr];

endmodule

// File: tb/tb_key_event_queue.sv
// tb/tb_key_event_queue.sv - directed self-checking bench for key_event_queue
module tb_key_event_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [10:0] frame = 11'h001;
  logic        frame_latch = 1'b0;
  logic        bat_strobe = 1'b0;
  logic        release_strobe = 1'b0;
  logic        extended_strobe = 1'b0;
  logic [9:0]  ev_data;
  logic        ev_valid;
  logic        ev_ready = 1'b0;
  logic        overflow;
  logic        kbd_reset;
  logic [7:0]  err_count;

  int checks = 0;
  int failures = 0;

  key_event_queue #(.DEPTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .frame(frame), .frame_latch(frame_latch),
    .bat_strobe(bat_strobe), .release_strobe(release_strobe),
    .extended_strobe(extended_strobe), .ev_data(ev_data), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .overflow(overflow), .kbd_reset(kbd_reset),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] mk_frame(input logic [7:0] code, input logic flip);
    logic par;
    par = ~(^code) ^ flip;
    return {1'b0, par, code, 1'b1};
  endfunction

  // which: 0 release, 1 extended, 2 frame_latch, 3 bat
  task automatic set_strobe(input int which, input logic v);
    case (which)
      0: release_strobe = v;
      1: extended_strobe = v;
      2: frame_latch = v;
      default: bat_strobe = v;
    endcase
  endtask

  task automatic pulse(input int which);
    @(negedge clk);
    set_strobe(which, 1'b1);
    repeat (4) @(negedge clk);
    set_strobe(which, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] code, input logic flip);
    @(negedge clk);
    frame = mk_frame(code, flip);
    pulse(2);
  endtask

  task automatic pop_one();
    @(negedge clk);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL reset_ev_valid got=%b exp=0", ev_valid); end
    checks++; if (ev_data !== 10'h000) begin failures++; $display("FAIL reset_ev_data got=%h exp=000", ev_data); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (kbd_reset !== 1'b0) begin failures++; $display("FAIL reset_kbd_reset got=%b exp=0", kbd_reset); end
    checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_prefix_frame();
    pulse(1);
    pulse(0);
    @(negedge clk);
    frame = mk_frame(8'h75, 1'b0);
    frame_latch = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", ev_valid); end
    @(posedge clk);
    #1;
    checks++; if (ev_valid !== 1'b1) begin failures++; $display("FAIL latency_valid got=%b exp=1", ev_valid); end
    checks++; if (ev_data !== 10'h375) begin failures++; $display("FAIL ext_rel_data got=%h exp=375", ev_data); end
    @(negedge clk);
    frame_latch = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ev_data !== 10'h375) begin failures++; $display("FAIL hold_data got=%h exp=375", ev_data); end
    pop_one();
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL pop_empty got=%b exp=0", ev_valid); end
  endtask

  task automatic test_bad_frame();
    send_frame(8'h1C, 1'b1);
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL bad_err_count got=%0d exp=1", err_count); end
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL bad_no_push got=%b exp=0", ev_valid); end
    pulse(1);
    send_frame(8'h1C, 1'b1);
    send_frame(8'h1C, 1'b0);
    checks++; if (ev_data !== 10'h01C) begin failures++; $display("FAIL bad_returns_idle got=%h exp=01C", ev_data); end
    pop_one();
    for (int i = 0; i < 256; i++) send_frame(8'h1C, 1'b1);
    checks++; if (err_count !== 8'd255) begin failures++; $display("FAIL err_saturate got=%0d exp=255", err_count); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 1'b0);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    checks++; if (ev_data !== 10'h010) begin failures++; $display("FAIL ovf_head got=%h exp=010", ev_data); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (ev_valid !== 1'b1 || ev_data !== 10'h010 + 10'(i)) begin
        failures++; $display("FAIL ovf_drain[%0d] got=%b/%h exp=1/%h", i, ev_valid, ev_data, 10'h010 + 10'(i));
      end
      pop_one();
    end
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%b exp=0", ev_valid); end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 8; i++) send_frame(8'h21 + 8'(i), 1'b0);
    @(negedge clk);
    frame = mk_frame(8'h29, 1'b0);
    frame_latch = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    frame_latch = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL full_pp_overflow got=%b exp=0", overflow); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (ev_valid !== 1'b1 || ev_data !== 10'h022 + 10'(i)) begin
        failures++; $display("FAIL full_pp_drain[%0d] got=%b/%h exp=1/%h", i, ev_valid, ev_data, 10'h022 + 10'(i));
      end
      pop_one();
    end
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL full_pp_count got=%b exp=0", ev_valid); end
  endtask

  task automatic test_bat();
    do_reset();
    send_frame(8'h1C, 1'b1);
    for (int i = 0; i < 3; i++) send_frame(8'h40 + 8'(i), 1'b0);
    checks++; if (ev_valid !== 1'b1) begin failures++; $display("FAIL bat_queued got=%b exp=1", ev_valid); end
    @(negedge clk);
    bat_strobe = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++; if (kbd_reset !== 1'b0) begin failures++; $display("FAIL bat_pulse_early got=%b exp=0", kbd_reset); end
    @(posedge clk);
    #1;
    checks++; if (kbd_reset !== 1'b1) begin failures++; $display("FAIL bat_pulse got=%b exp=1", kbd_reset); end
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL bat_flush got=%b exp=0", ev_valid); end
    @(posedge clk);
    #1;
    checks++; if (kbd_reset !== 1'b0) begin failures++; $display("FAIL bat_pulse_len got=%b exp=0", kbd_reset); end
    checks++; if (err_count !== 8'd1) begin failures++; $display("FAIL bat_err_kept got=%0d exp=1", err_count); end
    @(negedge clk);
    bat_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_midop();
    pulse(1);
    @(negedge clk);
    extended_strobe = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    extended_strobe = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (ev_valid !== 1'b0) begin failures++; $display("FAIL midrst_empty got=%b exp=0", ev_valid); end
    send_frame(8'h1C, 1'b0);
    checks++; if (ev_valid !== 1'b1 || ev_data !== 10'h01C) begin
      failures++; $display("FAIL midrst_entry got=%b/%h exp=1/01C", ev_valid, ev_data);
    end
  endtask

  initial begin
    test_reset();
    test_prefix_frame();
    test_bad_frame();
    test_overflow();
    test_full_push_pop();
    test_bat();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
